gate_sweep_checker: RTL and testbench

- Parametrised, self-running truth-table checker for N-input logic gates.
- Drives every input combination from 0 to 2^N_IN-1 into a gate under test and waits a programmable settle time.
- Samples the gate output and compares it to the expected function selected by mode.
- Reports pass/fail, an error count and the first failing vector; sits beside gate instances in lab benches and board-level self-test.

---
 rtl/gate_sweep_checker.sv | 167 ++++++++++++++++
 tb/tb_gate_sweep_checker.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker: exhaustive truth-table sweep and checker for N-input gates. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_sweep_checker #(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_mode,
    input  logic             i_dut_o,
    output logic [N_IN-1:0]  o_vec,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_mode_err,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_fail_valid,
    output logic [N_IN-1:0]  o_fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] c_settle_last = (SETTLE_CYC > 0) ? 8'(SETTLE_CYC - 1) : 8'd0;
    localparam state_t     c_run_state   = (SETTLE_CYC > 0) ? S_SETTLE : S_CHECK;

    state_t             state_q, state_d;
    logic [2:0]         mode_q, mode_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               pass_q, pass_d;
    logic               mode_err_q, mode_err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]    fail_vec_q, fail_vec_d;
    logic               expected;

    always_comb begin
        expected = 1'b0;
        case (mode_q)
            3'd0:    expected = &vec_q;
            3'd1:    expected = |vec_q;
            3'd2:    expected = ^vec_q;
            3'd3:    expected = ~&vec_q;
            3'd4:    expected = ~|vec_q;
            3'd5:    expected = ~^vec_q;
            default: expected = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        mode_err_d   = mode_err_q;
        err_cnt_d    = err_cnt_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    pass_d       = 1'b0;
                    err_cnt_d    = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    if (i_mode <= 3'd5) begin
                        mode_d     = i_mode;
                        vec_d      = '0;
                        cnt_d      = '0;
                        mode_err_d = 1'b0;
                        state_d    = c_run_state;
                    end else begin
                        // Reserved mode: report immediately, leave the driven vector alone
                        mode_err_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == c_settle_last) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CHECK: begin
                if (i_dut_o != expected) begin
                    if (err_cnt_q != {ERR_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                    end
                end
                if (&vec_q) begin
                    // Pass comes from the mismatch flag, since the count may saturate
                    pass_d  = ~fail_valid_d;
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = c_run_state;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q       <= '0;
            vec_q        <= '0;
            cnt_q        <= '0;
            pass_q       <= 1'b0;
            mode_err_q   <= 1'b0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            mode_q       <= mode_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            mode_err_q   <= mode_err_d;
            err_cnt_q    <= err_cnt_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign o_vec        = vec_q;
    assign o_busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign o_done       = (state_q == S_DONE);
    assign o_pass       = pass_q;
    assign o_mode_err   = mode_err_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_fail_valid = fail_valid_q;
    assign o_fail_vec   = fail_vec_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker: scoreboard bench for gate_sweep_checker over three parameter sets. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_sweep_checker;

    typedef struct packed {
        logic       done;
        logic       busy;
        logic       pass;
        logic       merr;
        logic       fv;
        logic [7:0] fvec;
        logic [7:0] err;
        logic [7:0] vec;
    } obs_t;

    typedef struct {
        int   k;
        obs_t o;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] mode;
    logic       start2, start3, start0;
    logic [2:0] sel2, sel3, sel0;
    logic       dut2, dut3, dut0;

    logic [1:0] vec2, fvec2;
    logic [7:0] err2;
    logic       busy2, done2, pass2, merr2, fv2;
    logic [2:0] vec3, fvec3;
    logic [7:0] err3;
    logic       busy3, done3, pass3, merr3, fv3;
    logic [2:0] vec0, fvec0;
    logic [1:0] err0;
    logic       busy0, done0, pass0, merr0, fv0;

    obs_t ob2, ob3, ob0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [7:0] trace[$];

    gate_sweep_checker #(.N_IN(2), .SETTLE_CYC(2), .ERR_W(8)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_mode(mode), .i_dut_o(dut2),
        .o_vec(vec2), .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_mode_err(merr2),
        .o_err_cnt(err2), .o_fail_valid(fv2), .o_fail_vec(fvec2));

    gate_sweep_checker #(.N_IN(3), .SETTLE_CYC(2), .ERR_W(8)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_mode(mode), .i_dut_o(dut3),
        .o_vec(vec3), .o_busy(busy3), .o_done(done3), .o_pass(pass3), .o_mode_err(merr3),
        .o_err_cnt(err3), .o_fail_valid(fv3), .o_fail_vec(fvec3));

    gate_sweep_checker #(.N_IN(3), .SETTLE_CYC(0), .ERR_W(2)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_mode(mode), .i_dut_o(dut0),
        .o_vec(vec0), .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_mode_err(merr0),
        .o_err_cnt(err0), .o_fail_valid(fv0), .o_fail_vec(fvec0));

    // Gate model: 0..5 ideal functions, 6 stuck at 0, 7 stuck at 1
    function automatic logic gate_fn(input logic [2:0] sel, input logic [7:0] v, input int n);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(v[i]);
        case (sel)
            3'd0: return ones == n;
            3'd1: return ones != 0;
            3'd2: return (ones % 2) == 1;
            3'd3: return ones != n;
            3'd4: return ones == 0;
            3'd5: return (ones % 2) == 0;
            3'd6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always_comb dut2 = gate_fn(sel2, {6'd0, vec2}, 2);
    always_comb dut3 = gate_fn(sel3, {5'd0, vec3}, 3);
    always_comb dut0 = gate_fn(sel0, {5'd0, vec0}, 3);

    assign ob2 = {done2, busy2, pass2, merr2, fv2, 6'd0, fvec2, err2, 6'd0, vec2};
    assign ob3 = {done3, busy3, pass3, merr3, fv3, 5'd0, fvec3, err3, 5'd0, vec3};
    assign ob0 = {done0, busy0, pass0, merr0, fv0, 5'd0, fvec0, 6'd0, err0, 5'd0, vec0};

    function automatic obs_t get_obs(input int inst);
        case (inst)
            2: return ob2;
            3: return ob3;
            default: return ob0;
        endcase
    endfunction

    function automatic obs_t mk(input logic d, input logic b, input logic p, input logic me,
                                input logic f, input int fvec, input int err, input int vec);
        obs_t r;
        r.done = d; r.busy = b; r.pass = p; r.merr = me; r.fv = f;
        r.fvec = 8'(fvec); r.err = 8'(err); r.vec = 8'(vec);
        return r;
    endfunction

    task automatic set_start(input int inst, input logic v);
        case (inst)
            2: start2 = v;
            3: start3 = v;
            default: start0 = v;
        endcase
    endtask

    // Starts one run and waits (bounded) for o_done; k counts edges after the accepting edge
    task automatic run_sweep(input int inst, input logic [2:0] m, input bit disturb,
                             output int k, output obs_t o);
        obs_t cur;
        trace.delete();
        @(negedge clk);
        mode = m;
        set_start(inst, 1'b1);
        @(negedge clk);
        set_start(inst, 1'b0);
        k = 0;
        cur = get_obs(inst);
        while (!cur.done && k < 200) begin
            trace.push_back(cur.vec);
            if (disturb && k == 5) begin
                set_start(inst, 1'b1);
                mode = 3'd0;
            end
            if (disturb && k == 6) set_start(inst, 1'b0);
            @(negedge clk);
            k++;
            cur = get_obs(inst);
        end
        o = cur;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (ob2 !== '0) begin $display("FAIL reset_u2: got %h expected 0", ob2); n_err++; end
        n_vec++;
        if (ob3 !== '0) begin $display("FAIL reset_u3: got %h expected 0", ob3); n_err++; end
        n_vec++;
        if (ob0 !== '0) begin $display("FAIL reset_u0: got %h expected 0", ob0); n_err++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_and_sweep();
        int k; obs_t o; exp_t e;
        logic [7:0] exp_tr[$];
        sel2 = 3'd0;
        for (int v = 0; v < 4; v++) for (int r = 0; r < 3; r++) exp_tr.push_back(8'(v));
        sb.push_back('{k: 12, o: mk(1, 0, 1, 0, 0, 0, 0, 3)});
        run_sweep(2, 3'd0, 1'b0, k, o);
        n_vec++;
        if (trace.size() != exp_tr.size()) begin
            $display("FAIL and_trace_len: got %0d expected %0d", trace.size(), exp_tr.size());
            n_err++;
        end else begin
            for (int i = 0; i < exp_tr.size(); i++) begin
                n_vec++;
                if (trace[i] !== exp_tr[i]) begin
                    $display("FAIL and_vec[%0d]: got %0d expected %0d", i, trace[i], exp_tr[i]);
                    n_err++;
                end
            end
        end
        e = sb.pop_front();
        n_vec++;
        if (k !== e.k) begin $display("FAIL and_latency: got %0d expected %0d", k, e.k); n_err++; end
        n_vec++;
        if (o !== e.o) begin $display("FAIL and_result: got %h expected %h", o, e.o); n_err++; end
    endtask

    task automatic test_stuck0_or();
        int k; obs_t o; exp_t e;
        sel3 = 3'd6;
        sb.push_back('{k: 24, o: mk(1, 0, 0, 0, 1, 1, 7, 7)});
        run_sweep(3, 3'd1, 1'b0, k, o);
        e = sb.pop_front();
        n_vec++;
        if (k !== e.k) begin $display("FAIL or_latency: got %0d expected %0d", k, e.k); n_err++; end
        n_vec++;
        if (o !== e.o) begin $display("FAIL or_stuck0: got %h expected %h", o, e.o); n_err++; end
    endtask

    task automatic test_saturate();
        int k; obs_t o; exp_t e;
        sel0 = 3'd7;
        sb.push_back('{k: 8, o: mk(1, 0, 0, 0, 1, 0, 3, 7)});
        run_sweep(0, 3'd0, 1'b0, k, o);
        e = sb.pop_front();
        n_vec++;
        if (k !== e.k) begin $display("FAIL sat_latency: got %0d expected %0d", k, e.k); n_err++; end
        n_vec++;
        if (o !== e.o) begin $display("FAIL sat_result: got %h expected %h", o, e.o); n_err++; end
    endtask

    task automatic test_modes();
        int k; obs_t o; exp_t e;
        for (int m = 2; m <= 5; m++) begin
            sel3 = 3'(m);
            sb.push_back('{k: 24, o: mk(1, 0, 1, 0, 0, 0, 0, 7)});
            run_sweep(3, 3'(m), 1'b0, k, o);
            e = sb.pop_front();
            n_vec++;
            if (k !== e.k || o !== e.o) begin
                $display("FAIL mode%0d_pass: got k=%0d %h expected k=%0d %h", m, k, o, e.k, e.o);
                n_err++;
            end
        end
        sel3 = 3'd0;
        sb.push_back('{k: 24, o: mk(1, 0, 0, 0, 1, 0, 8, 7)});
        run_sweep(3, 3'd3, 1'b0, k, o);
        e = sb.pop_front();
        n_vec++;
        if (o !== e.o) begin $display("FAIL nand_vs_and: got %h expected %h", o, e.o); n_err++; end
    endtask

    task automatic test_disturb();
        int k; obs_t o; exp_t e;
        sel3 = 3'd6;
        sb.push_back('{k: 24, o: mk(1, 0, 0, 0, 1, 1, 7, 7)});
        run_sweep(3, 3'd1, 1'b1, k, o);
        e = sb.pop_front();
        n_vec++;
        if (k !== e.k) begin $display("FAIL disturb_latency: got %0d expected %0d", k, e.k); n_err++; end
        n_vec++;
        if (o !== e.o) begin $display("FAIL disturb_result: got %h expected %h", o, e.o); n_err++; end
    endtask

    task automatic test_reserved();
        int k; obs_t o; exp_t e;
        sel3 = 3'd2;
        sb.push_back('{k: 24, o: mk(1, 0, 1, 0, 0, 0, 0, 7)});
        run_sweep(3, 3'd2, 1'b0, k, o);
        e = sb.pop_front();
        n_vec++;
        if (o !== e.o) begin $display("FAIL pre_reserved: got %h expected %h", o, e.o); n_err++; end
        sb.push_back('{k: 0, o: mk(1, 0, 0, 1, 0, 0, 0, 7)});
        run_sweep(3, 3'd7, 1'b0, k, o);
        e = sb.pop_front();
        n_vec++;
        if (k !== e.k) begin $display("FAIL reserved_latency: got %0d expected %0d", k, e.k); n_err++; end
        n_vec++;
        if (o !== e.o) begin $display("FAIL reserved_result: got %h expected %h", o, e.o); n_err++; end
        @(negedge clk);
        n_vec++;
        if (ob3 !== mk(0, 0, 0, 1, 0, 0, 0, 7)) begin
            $display("FAIL reserved_hold: got %h expected %h", ob3, mk(0, 0, 0, 1, 0, 0, 0, 7));
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int got[$];
        int exp_k[$];
        exp_k.push_back(8);
        exp_k.push_back(18);
        sel0 = 3'd0;
        @(negedge clk);
        mode = 3'd0;
        start0 = 1'b1;
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);
            if (done0) got.push_back(k);
        end
        start0 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (got.size() != 2) begin
            $display("FAIL b2b_pulses: got %0d expected 2", got.size());
            n_err++;
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (got[i] != exp_k[i]) begin
                    $display("FAIL b2b_done[%0d]: got %0d expected %0d", i, got[i], exp_k[i]);
                    n_err++;
                end
            end
        end
        n_vec++;
        if (ob0 !== mk(0, 0, 1, 0, 0, 0, 0, 7)) begin
            $display("FAIL b2b_idle: got %h expected %h", ob0, mk(0, 0, 1, 0, 0, 0, 0, 7));
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        int dones = 0;
        sel2 = 3'd0;
        @(negedge clk);
        mode = 3'd0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        while (vec2 !== 2'd2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (vec2 !== 2'd2) begin $display("FAIL mid_reach_vec2: got %0d expected 2", vec2); n_err++; end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (ob2 !== '0) begin $display("FAIL mid_reset_async: got %h expected 0", ob2); n_err++; end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done2) dones++;
            if (i == 3) rst_n = 1'b1;
        end
        n_vec++;
        if (dones != 0) begin $display("FAIL mid_reset_done: got %0d expected 0", dones); n_err++; end
        n_vec++;
        if (ob2 !== '0) begin $display("FAIL mid_reset_hold: got %h expected 0", ob2); n_err++; end
    endtask

    initial begin
        rst_n  = 1'b0;
        mode   = 3'd0;
        start2 = 1'b0;
        start3 = 1'b0;
        start0 = 1'b0;
        sel2   = 3'd0;
        sel3   = 3'd0;
        sel0   = 3'd0;
        test_reset();
        test_and_sweep();
        test_stuck0_or();
        test_saturate();
        test_modes();
        test_disturb();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
